vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and drives the DrawX/DrawY coordinates consumed by background_mapper and later sprite stages. hs, vs and video_on are delayed by a parameterised number of pixels so that they line up with the colour produced by the synchronous-ROM lookup downstream. It also provides a pixel clock enable and line/frame start strobes for game logic.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); line total 800
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); frame total 525
CLK_DIV, 2, system clocks per pixel; legal range 1..4
PIPE_LAT, 2, pixel delay applied to hs/vs/video_on; legal range 1..4

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
pixel_ce  out  1  one-clock pixel enable, asserted once every CLK_DIV clocks
DrawX  out  10  current horizontal count 0..799; undelayed
DrawY  out  10  current vertical count 0..524; undelayed
hs  out  1  horizontal sync, active low, delayed PIPE_LAT pixels
vs  out  1  vertical sync, active low, delayed PIPE_LAT pixels
video_on  out  1  high in the visible region, delayed PIPE_LAT pixels
line_start  out  1  equals pixel_ce AND DrawX==0
frame_start  out  1  equals pixel_ce AND DrawX==0 AND DrawY==0

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: div_cnt=0, DrawX=0, DrawY=0, pixel_ce=0, line_start=0, frame_start=0, hs=1, vs=1, video_on=0. Every delay-line stage loads the inactive values (hs=1, vs=1, video_on=0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_ce = (div_cnt==CLK_DIV-1) and not reset.
  - With CLK_DIV=1, pixel_ce is constantly 1 outside reset.
- Counters: advance only on clock edges where pixel_ce=1.
  - DrawX increments and wraps 799->0.
  - On the DrawX wrap, DrawY increments and wraps 524->0.
- Raw sync and visibility, decoded from the current counters:
  - hs_raw low when DrawX is in [656,751].
  - vs_raw low when DrawY is in [490,491].
  - vis_raw high when DrawX<640 AND DrawY<480.
- Delay line:
  - PIPE_LAT-deep shift register, 3 bits wide, advanced only on pixel_ce.
  - The outputs are the last stage, registered.
  - Result: hs/vs/video_on during pixel n reflect the counter state of pixel n-PIPE_LAT.
- Strobes:
  - line_start and frame_start are combinational from pixel_ce and the counter registers.
  - They are valid in the same cycle in which the counters show the start position.
- First frame after reset (CLK_DIV=2): the first pixel_ce is at clock 1 after release, with DrawX=0 and DrawY=0, so frame_start=1 at clock 1.
- Reset mid-frame: all state returns to reset values immediately without waiting for a clock edge. No partial sync pulse is extended. Timing restarts at (0,0).
- Width rule: counters are 10-bit unsigned, and comparisons use derived constants only. Totals must stay ≤1023; out-of-range parameters are a static elaboration error.

Decomposition:
- Package vga_timing_pkg holds:
  - derived constants H_TOTAL, V_TOTAL, H_SYNC_START, H_SYNC_END, V_SYNC_START, V_SYNC_END;
  - a packed struct vga_ctl_t {hs, vs, video_on};
  - the inactive constant VGA_CTL_IDLE.
- Sub-module vga_ctl_delay: a parameterised, enable-gated shift register of vga_ctl_t. It takes clock, reset, ce, d and q, and has depth PIPE_LAT.

Test Plan:
- Reset release, CLK_DIV=2 -> pixel_ce sequence 0,1,0,1…; frame_start=1 at clock 1; DrawX reads 1 at clocks 2-3 and 2 at clocks 4-5.
- Line wrap: run to DrawX=799, DrawY=10, then one pixel_ce -> DrawX=0, DrawY=11, line_start=1, frame_start=0.
- hsync alignment, PIPE_LAT=2 -> hs first low on the pixel where DrawX=658; stays low exactly 96 pixel_ce; rises where DrawX=754.
- Frame wrap: from (799,524), one pixel_ce -> (0,0) with frame_start=1. vs is low for exactly 1600 pixel_ce per frame, starting where DrawX=2 and DrawY=490.
- Visible count -> video_on high for 640 consecutive pixels per line on lines 0..479 and 307200 pixels per frame. It is never high while hs=0.
- Async reset at DrawX=300, DrawY=100, asserted between clock edges -> DrawX=0, DrawY=0, hs=1, vs=1, video_on=0 before the next edge. After release, frame_start occurs at clock 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA timing generator.
//   coord_t      : 10-bit unsigned pixel/line coordinate
//   vga_ctl_t    : packed {hs, vs, video_on} carried through the alignment delay
//   VGA_CTL_IDLE : inactive control value (syncs high, video off)
//   H_TOTAL .. V_SYNC_END : derived constants of the standard 640x480@60 mode
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic video_on;
    } vga_ctl_t;

    localparam vga_ctl_t VGA_CTL_IDLE = '{hs: 1'b1, vs: 1'b1, video_on: 1'b0};

    // Standard 640x480@60 geometry (visible + front porch + sync + back porch).
    localparam int unsigned H_TOTAL      = 640 + 16 + 96 + 48;
    localparam int unsigned V_TOTAL      = 480 + 10 + 2 + 33;
    localparam int unsigned H_SYNC_START = 640 + 16;
    localparam int unsigned H_SYNC_END   = 640 + 16 + 96 - 1;
    localparam int unsigned V_SYNC_START = 480 + 10;
    localparam int unsigned V_SYNC_END   = 480 + 10 + 2 - 1;

    // Inclusive range test on a coordinate.
    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_ctl_delay.sv
// Enable-gated shift register of vga_ctl_t used to align hs/vs/video_on with the
// colour produced by the downstream synchronous ROM lookup.
//   clock : system clock
//   reset : asynchronous, active-high; every stage loads VGA_CTL_IDLE
//   ce    : shift enable (one pixel)
//   d     : undelayed control bits
//   q     : control bits delayed by DEPTH enabled cycles (last stage register)
module vga_ctl_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     ce,
    input  vga_ctl_t d,
    output vga_ctl_t q
);

    vga_ctl_t stage_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= VGA_CTL_IDLE;
            end
        end else if (ce) begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel clock enable, horizontal/vertical counters, sync and
// visibility decode, and a PIPE_LAT-pixel delay on hs/vs/video_on.
//   clock       : system clock (50 MHz)
//   reset       : asynchronous, active-high
//   pixel_ce    : one-clock pixel enable, every CLK_DIV clocks
//   DrawX/DrawY : current (undelayed) horizontal/vertical counts
//   hs/vs       : active-low syncs, delayed PIPE_LAT pixels
//   video_on    : visible region, delayed PIPE_LAT pixels
//   line_start  : pixel_ce while DrawX==0
//   frame_start : pixel_ce while DrawX==0 and DrawY==0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_LEN = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_LEN = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST = coord_t'(H_LEN - 1);
    localparam coord_t Y_LAST = coord_t'(V_LEN - 1);
    localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    // Reject geometries or rates the 10-bit counters and 2-bit divider cannot hold.
    if (H_LEN > 1023 || V_LEN > 1023) begin : g_bad_total
        $error("vga_timing_gen: line or frame total exceeds 1023");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be 1..4");
    end
    if (PIPE_LAT < 1 || PIPE_LAT > 4) begin : g_bad_pipe_lat
        $error("vga_timing_gen: PIPE_LAT must be 1..4");
    end
    if (H_VISIBLE < 1 || H_SYNC < 1 || V_VISIBLE < 1 || V_SYNC < 1) begin : g_bad_geom
        $error("vga_timing_gen: visible and sync widths must be non-zero");
    end

    logic [1:0] div_q, div_d;
    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    vga_ctl_t   ctl_raw;
    vga_ctl_t   ctl_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            if (pixel_ce) begin
                x_q <= x_d;
                y_q <= y_d;
            end
        end
    end

    always_comb begin
        div_d = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
        x_d   = x_q + 10'd1;
        y_d   = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Gated by reset so no enable escapes while reset is held.
    assign pixel_ce = (div_q == DIV_LAST) && !reset;

    always_comb begin
        ctl_raw          = VGA_CTL_IDLE;
        ctl_raw.hs       = !in_span(x_q, HS_LO, HS_HI);
        ctl_raw.vs       = !in_span(y_q, VS_LO, VS_HI);
        ctl_raw.video_on = (x_q < X_VIS) && (y_q < Y_VIS);
    end

    vga_ctl_delay #(
        .DEPTH(PIPE_LAT)
    ) u_ctl_delay (
        .clock(clock),
        .reset(reset),
        .ce   (pixel_ce),
        .d    (ctl_raw),
        .q    (ctl_q)
    );

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = ctl_q.hs;
    assign vs          = ctl_q.vs;
    assign video_on    = ctl_q.video_on;
    assign line_start  = pixel_ce && (x_q == 10'd0);
    assign frame_start = pixel_ce && (x_q == 10'd0) && (y_q == 10'd0);

endmodule
